bubble_page_usb_tx: RTL and testbench
=====================================

# bubble_page_usb_tx

Reader and transmitter for the bubble page bit buffer. The emulator core writes decoded page bits one at a time and then pulses a send request. This block stores those bits and streams them to the host over the FT232 asynchronous 245-FIFO write interface as framed bytes. It sits between the emulator core's FIFO-buffer write port and the ADBUS/ACBUS pins, and replaces the host-bound data path inside the USB block.

## Interface
Parameters:
- WR_LOW, 4: MCLK cycles that nFTWR is held low per byte.
- WR_HIGH, 6: MCLK cycles that nFTWR is held high after each strobe. Must cover FT232 nTXE response time plus the 2-cycle synchronizer.

Ports:
- MCLK  in  1  48 MHz system clock. The block has one clock.
- RST  in  1  Synchronous, active-high reset.
- nEN  in  1  Active-low enable. While high, the block idles and send requests are ignored.
- BITWIDTH4  in  1  Selects user payload size. 1 → 256 bytes, 0 → 128 bytes.
- nFIFOBUFWRCLKEN  in  1  Active-low bit write strobe, sampled each MCLK cycle.
- FIFOBUFWRADDR  in  13  Bit address for the write.
- FIFOBUFWRDATA  in  1  Bit value for the write.
- nFIFOSENDBOOT  in  1  Active-low boot-loop send request. Triggers on the falling edge.
- nFIFOSENDUSER  in  1  Active-low user-page send request. Triggers on the falling edge.
- FIFORELPAGE  in  12  Relative page number. Latched when a request is accepted.
- nFTTXE  in  1  FT232 transmit-FIFO-full flag (active-low "space available"). Asynchronous to MCLK.
- nFTWR  out  1  FT232 write strobe, active low.
- FTDO  out  8  Data driven onto ADBUS.
- FTDOE  out  1  Output enable for ADBUS.
- BUSY  out  1  High while a frame is in progress.
- OVERRUN  out  1  Sticky flag: a request arrived while BUSY. Cleared only by RST.

## Operation
Buffer:
- 8192 bits of storage, organised as 1024×8 with bit-granular write.
- A bit write goes to byte FIFOBUFWRADDR[12:3], bit FIFOBUFWRADDR[2:0]. Bytes are packed LSB first.
- Writes are accepted in every state, including while BUSY. The emulator core must not overwrite bits while BUSY.
- RST does not clear the buffer.
- Read latency is 1 cycle.

Request handling:
- Each request input is registered, and a falling edge is detected.
- Requests are accepted only in IDLE with nEN=0.
- If both requests fall in the same cycle, boot wins and the user request is dropped silently.
- A falling edge on either request while BUSY sets OVERRUN. The request is dropped.

Frame format, in byte order:
- Byte 0: type. 0xB5 for boot, 0xA5 for user.
- Byte 1: {4'h0, FIFORELPAGE[11:8]}.
- Byte 2: FIFORELPAGE[7:0].
- Payload: boot sends buffer bytes 0..1023. User sends bytes 0..255 (BITWIDTH4=1) or 0..127 (BITWIDTH4=0).
- Last byte: XOR checksum of all payload bytes. Header bytes are not included.

State machine:
- IDLE → HDR on an accepted request. FIFORELPAGE, request type and BITWIDTH4 are latched.
- HDR, PAYLOAD and CKSUM each send one byte through the shared byte-send sequence below, then advance.
- Byte-send sequence:
  - WAIT_TXE: wait for synchronized nFTTXE=0.
  - SETUP: drive FTDO with the byte for 1 cycle.
  - STROBE: nFTWR=0 for WR_LOW cycles.
  - HOLD: nFTWR=1 and FTDO held for WR_HIGH cycles.
- The payload byte address counter is 10 bits. The frame ends on terminal count; the counter never wraps into unsent data.
- After the CKSUM HOLD completes, go to IDLE.

nEN going high mid-frame:
- The current byte-send sequence completes; an nFTWR low pulse is never truncated.
- The block then goes to IDLE. No checksum is sent.

## Timing
Reset values: nFTWR=1, FTDO=0x00, FTDOE=0, BUSY=0, OVERRUN=0, state IDLE.

Start of frame:
- Request falling edge at cycle N is detected at N+1.
- BUSY=1 from N+2.
- HDR WAIT_TXE begins at N+2.

Output enable:
- FTDOE=1 from the first SETUP until the return to IDLE.
- FTDOE=0 in the cycle after the return to IDLE.

nFTTXE:
- Passes through a 2-flop synchronizer, adding 2 cycles of latency.
- While synchronized nFTTXE=1, nFTWR stays high indefinitely. There is no timeout.

Per-byte timing:
- Minimum byte period is 1 + 1 + WR_LOW + WR_HIGH = 12 cycles with default parameters.
- FTDO is stable from SETUP through the end of HOLD.

Minimum frame lengths:
- Boot frame: 1028 bytes, 12336 cycles.
- User frame: 260 or 132 bytes.

Reset mid-operation: one MCLK edge after RST=1, nFTWR=1, FTDOE=0 and BUSY=0.

## Test plan
- Write bits so that byte0=0x5A and byte1=0xC3, rest 0. Assert nFIFOSENDUSER with FIFORELPAGE=0x123 and BITWIDTH4=0. Expected: 132 strobes carrying A5 01 23 5A C3 00… and checksum 0x99; nFTWR low exactly 4 cycles each; BUSY low after the last HOLD.
- Buffer all 0xFF, nFIFOSENDBOOT asserted, FIFORELPAGE=0xFFF. Expected: 1028 bytes B5 0F FF, then 1024 × FF, then checksum 0x00.
- Hold nFTTXE high for 100 cycles after byte 1. Expected: nFTWR stays high and FTDO holds 0x01 throughout; byte 2 strobes 3–4 cycles after nFTTXE falls.
- Both requests fall in the same cycle, then a second user request arrives mid-frame. Expected: a boot frame only; OVERRUN=1 and stays 1 after the frame.
- Assert RST during a STROBE. Expected: next cycle nFTWR=1, FTDOE=0, BUSY=0, OVERRUN=0. A following user request produces a full frame with the buffer contents intact.
- Drive nEN high during payload byte 10. Expected: byte 10's strobe completes at full WR_LOW; no further strobes; BUSY=0 after its HOLD.

Source files
------------

// File: rtl/bubble_page_usb_tx.sv
// Bubble page bit buffer plus framed byte transmitter for the FT232 async 245-FIFO.
// Frames are: type, page hi, page lo, payload bytes, XOR checksum of the payload.
module bubble_page_usb_tx #(
  parameter int WR_LOW  = 4,
  parameter int WR_HIGH = 6
) (
  input  logic        MCLK,
  input  logic        RST,
  input  logic        nEN,
  input  logic        BITWIDTH4,
  input  logic        nFIFOBUFWRCLKEN,
  input  logic [12:0] FIFOBUFWRADDR,
  input  logic        FIFOBUFWRDATA,
  input  logic        nFIFOSENDBOOT,
  input  logic        nFIFOSENDUSER,
  input  logic [11:0] FIFORELPAGE,
  input  logic        nFTTXE,
  output logic        nFTWR,
  output logic [7:0]  FTDO,
  output logic        FTDOE,
  output logic        BUSY,
  output logic        OVERRUN
);

  localparam int CMAX = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_TXE, S_SETUP, S_STROBE, S_HOLD} state_e;
  typedef enum logic [2:0] {P_HDR0, P_HDR1, P_HDR2, P_PAYLOAD, P_CKSUM} phase_e;

  state_e        state_q;
  phase_e        phase_q;
  logic [7:0]    mem_q [1024];
  logic [7:0]    rd_q;
  logic [1:0]    boot_q, user_q, txe_q;
  logic [CW-1:0] cnt_q;
  logic [9:0]    addr_q;
  logic          last_q;
  logic [7:0]    cks_q;
  logic          is_boot_q, bw4_q;
  logic [11:0]   page_q;
  logic          nftwr_q, ftdoe_q, busy_q, overrun_q;
  logic [7:0]    ftdo_q;

  logic          boot_fall, user_fall;
  logic [7:0]    tx_byte;
  logic [9:0]    last_addr;

  assign boot_fall = boot_q[1] & ~boot_q[0];
  assign user_fall = user_q[1] & ~user_q[0];

  // NOTE: the buffer is deliberately left out of reset so contents survive RST
  // and the array maps onto block RAM.
  always_ff @(posedge MCLK) begin
    if (!nFIFOBUFWRCLKEN) mem_q[FIFOBUFWRADDR[12:3]][FIFOBUFWRADDR[2:0]] <= FIFOBUFWRDATA;
    rd_q <= mem_q[addr_q];
  end

  always_comb begin
    tx_byte = 8'h00;
    unique case (phase_q)
      P_HDR0:    tx_byte = is_boot_q ? 8'hB5 : 8'hA5;
      P_HDR1:    tx_byte = {4'h0, page_q[11:8]};
      P_HDR2:    tx_byte = page_q[7:0];
      P_PAYLOAD: tx_byte = rd_q;
      P_CKSUM:   tx_byte = cks_q;
      default:   tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    last_addr = 10'h3FF;
    if (!is_boot_q) last_addr = bw4_q ? 10'h0FF : 10'h07F;
  end

  always_ff @(posedge MCLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      phase_q   <= P_HDR0;
      boot_q    <= 2'b11;
      user_q    <= 2'b11;
      txe_q     <= 2'b11;
      cnt_q     <= '0;
      addr_q    <= '0;
      last_q    <= 1'b0;
      cks_q     <= 8'h00;
      is_boot_q <= 1'b0;
      bw4_q     <= 1'b0;
      page_q    <= 12'h000;
      nftwr_q   <= 1'b1;
      ftdo_q    <= 8'h00;
      ftdoe_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      boot_q <= {boot_q[0], nFIFOSENDBOOT};
      user_q <= {user_q[0], nFIFOSENDUSER};
      txe_q  <= {txe_q[0], nFTTXE};
      if (state_q != S_IDLE && (boot_fall || user_fall)) overrun_q <= 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (!nEN && (boot_fall || user_fall)) begin
            state_q   <= S_WAIT_TXE;
            phase_q   <= P_HDR0;
            busy_q    <= 1'b1;
            is_boot_q <= boot_fall;
            page_q    <= FIFORELPAGE;
            bw4_q     <= BITWIDTH4;
            addr_q    <= '0;
            last_q    <= 1'b0;
            cks_q     <= 8'h00;
          end
        end
        S_WAIT_TXE: begin
          if (!txe_q[1]) begin
            state_q <= S_SETUP;
            ftdo_q  <= tx_byte;
            ftdoe_q <= 1'b1;
            if (phase_q == P_PAYLOAD) cks_q <= cks_q ^ rd_q;
          end
        end
        S_SETUP: begin
          state_q <= S_STROBE;
          nftwr_q <= 1'b0;
          cnt_q   <= '0;
        end
        S_STROBE: begin
          if (cnt_q == CW'(WR_LOW - 1)) begin
            state_q <= S_HOLD;
            nftwr_q <= 1'b1;
            cnt_q   <= '0;
            // Advance early so the next payload byte is read back well before SETUP.
            if (phase_q == P_PAYLOAD) begin
              if (addr_q == last_addr) last_q <= 1'b1;
              else addr_q <= addr_q + 10'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_q == CW'(WR_HIGH - 1)) begin
            cnt_q <= '0;
            if (phase_q == P_CKSUM || nEN) begin
              state_q <= S_IDLE;
              ftdoe_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_WAIT_TXE;
              unique case (phase_q)
                P_HDR0:    phase_q <= P_HDR1;
                P_HDR1:    phase_q <= P_HDR2;
                P_HDR2:    phase_q <= P_PAYLOAD;
                P_PAYLOAD: if (last_q) phase_q <= P_CKSUM;
                default:   phase_q <= P_HDR0;
              endcase
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign nFTWR   = nftwr_q;
  assign FTDO    = ftdo_q;
  assign FTDOE   = ftdoe_q;
  assign BUSY    = busy_q;
  assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_bubble_page_usb_tx.sv
// Directed bench for bubble_page_usb_tx: captures every nFTWR strobe and
// compares whole frames against hand-built expected byte lists.
module tb_bubble_page_usb_tx;

  localparam int WR_LOW  = 4;
  localparam int WR_HIGH = 6;

  logic        MCLK = 1'b0;
  logic        RST, nEN, BITWIDTH4, nFIFOBUFWRCLKEN, FIFOBUFWRDATA;
  logic [12:0] FIFOBUFWRADDR;
  logic        nFIFOSENDBOOT, nFIFOSENDUSER, nFTTXE;
  logic [11:0] FIFORELPAGE;
  logic        nFTWR, FTDOE, BUSY, OVERRUN;
  logic [7:0]  FTDO;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] bytes_q[$];
  logic [7:0] exp_q[$];
  int         lowlen_q[$];
  int         stable_err = 0;
  int         low_cnt    = 0;
  logic       prev_wr    = 1'b1;
  logic [7:0] fall_data  = 8'h00;

  bubble_page_usb_tx #(.WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH)) dut (
    .MCLK(MCLK), .RST(RST), .nEN(nEN), .BITWIDTH4(BITWIDTH4),
    .nFIFOBUFWRCLKEN(nFIFOBUFWRCLKEN), .FIFOBUFWRADDR(FIFOBUFWRADDR),
    .FIFOBUFWRDATA(FIFOBUFWRDATA), .nFIFOSENDBOOT(nFIFOSENDBOOT),
    .nFIFOSENDUSER(nFIFOSENDUSER), .FIFORELPAGE(FIFORELPAGE), .nFTTXE(nFTTXE),
    .nFTWR(nFTWR), .FTDO(FTDO), .FTDOE(FTDOE), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 MCLK = ~MCLK;

  // Strobe monitor: records the byte on each nFTWR fall and the low-pulse length.
  always @(negedge MCLK) begin
    if (prev_wr === 1'b1 && nFTWR === 1'b0) begin
      bytes_q.push_back(FTDO);
      fall_data = FTDO;
      low_cnt   = 1;
    end else if (nFTWR === 1'b0) begin
      low_cnt++;
      if (FTDO !== fall_data) stable_err++;
    end else if (prev_wr === 1'b0) begin
      lowlen_q.push_back(low_cnt);
    end
    prev_wr = nFTWR;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic wr_bit(input logic [12:0] a, input logic d);
    nFIFOBUFWRCLKEN = 1'b0;
    FIFOBUFWRADDR   = a;
    FIFOBUFWRDATA   = d;
    tick();
    nFIFOBUFWRCLKEN = 1'b1;
  endtask

  task automatic write_byte(input logic [9:0] b, input logic [7:0] v);
    for (int i = 0; i < 8; i++) wr_bit({b, 3'(i)}, v[i]);
  endtask

  task automatic clear_capture();
    bytes_q.delete();
    lowlen_q.delete();
    stable_err = 0;
  endtask

  task automatic pulse_user();
    nFIFOSENDUSER = 1'b0;
    tick();
    tick();
    nFIFOSENDUSER = 1'b1;
  endtask

  task automatic wait_busy_low(input string tag, input int budget);
    int n = 0;
    while (BUSY === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_busy_low"}, BUSY, 1'b0);
  endtask

  task automatic wait_bytes(input string tag, input int k, input int budget);
    int n = 0;
    while (bytes_q.size() < k && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_reached"}, bytes_q.size() >= k, 1'b1);
  endtask

  task automatic check_frame(input string tag);
    int bad    = 0;
    int badlen = 0;
    check({tag, "_count"}, bytes_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < bytes_q.size(); i++)
      if (bytes_q[i] !== exp_q[i]) bad++;
    check({tag, "_bytes"}, bad, 0);
    if (bytes_q.size() > 0) check({tag, "_cksum"}, bytes_q[bytes_q.size()-1], exp_q[exp_q.size()-1]);
    foreach (lowlen_q[i]) if (lowlen_q[i] != WR_LOW) badlen++;
    check({tag, "_lowlen"}, badlen, 0);
    check({tag, "_pulses"}, lowlen_q.size(), exp_q.size());
    check({tag, "_ftdo_stable"}, stable_err, 0);
  endtask

  initial begin
    int n;
    int bad;
    RST = 1'b1; nEN = 1'b0; BITWIDTH4 = 1'b0;
    nFIFOBUFWRCLKEN = 1'b1; FIFOBUFWRADDR = '0; FIFOBUFWRDATA = 1'b0;
    nFIFOSENDBOOT = 1'b1; nFIFOSENDUSER = 1'b1; FIFORELPAGE = '0; nFTTXE = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    check("rst_nftwr", nFTWR, 1'b1);
    check("rst_ftdo", FTDO, 8'h00);
    check("rst_ftdoe", FTDOE, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_overrun", OVERRUN, 1'b0);

    // User frame, 128-byte payload, with a TXE stall after byte 1.
    for (int b = 0; b < 128; b++) write_byte(10'(b), (b == 0) ? 8'h5A : (b == 1) ? 8'hC3 : 8'h00);
    clear_capture();
    FIFORELPAGE = 12'h123; BITWIDTH4 = 1'b0;
    nFIFOSENDUSER = 1'b0;
    tick();
    check("start_n1_busy", BUSY, 1'b0);
    tick();
    check("start_n2_busy", BUSY, 1'b1);
    check("start_n2_ftdoe", FTDOE, 1'b0);
    nFIFOSENDUSER = 1'b1; FIFORELPAGE = 12'h000; BITWIDTH4 = 1'b1;
    tick();
    check("setup_ftdo", FTDO, 8'hA5);
    check("setup_ftdoe", FTDOE, 1'b1);
    check("setup_nftwr", nFTWR, 1'b1);
    tick();
    check("strobe_nftwr", nFTWR, 1'b0);
    n = 0;
    while (lowlen_q.size() < 2 && n < 100) begin tick(); n++; end
    check("byte1_done", lowlen_q.size(), 2);
    nFTTXE = 1'b1;
    bad = 0;
    repeat (100) begin
      tick();
      if (nFTWR !== 1'b1 || FTDO !== 8'h01) bad++;
    end
    check("stall_hold", bad, 0);
    check("stall_no_strobe", bytes_q.size(), 2);
    nFTTXE = 1'b0;
    n = 0;
    while (nFTWR === 1'b1 && n < 20) begin tick(); n++; end
    check("txe_resume_latency", (n >= 3 && n <= 4), 1'b1);
    wait_busy_low("user1", 3000);
    check("user1_ftdoe_off", FTDOE, 1'b0);
    check("user1_nftwr_idle", nFTWR, 1'b1);
    exp_q.delete();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'h23);
    exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
    repeat (126) exp_q.push_back(8'h00);
    exp_q.push_back(8'h99);
    check_frame("user1");

    // Boot frame of all-ones; simultaneous requests, then a mid-frame overrun.
    for (int b = 0; b < 1024; b++) write_byte(10'(b), 8'hFF);
    clear_capture();
    FIFORELPAGE = 12'hFFF; BITWIDTH4 = 1'b0;
    nFIFOSENDBOOT = 1'b0; nFIFOSENDUSER = 1'b0;
    tick();
    tick();
    nFIFOSENDBOOT = 1'b1; nFIFOSENDUSER = 1'b1;
    wait_bytes("boot_mid", 50, 1000);
    check("boot_no_overrun_yet", OVERRUN, 1'b0);
    pulse_user();
    check("overrun_set", OVERRUN, 1'b1);
    wait_busy_low("boot", 13000);
    check("overrun_sticky", OVERRUN, 1'b1);
    exp_q.delete();
    exp_q.push_back(8'hB5); exp_q.push_back(8'h0F); exp_q.push_back(8'hFF);
    repeat (1024) exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    check_frame("boot");
    repeat (20) tick();
    check("boot_no_followup", BUSY, 1'b0);

    // Reset during a strobe, then a 256-byte user frame from the retained buffer.
    clear_capture();
    FIFORELPAGE = 12'h0A5; BITWIDTH4 = 1'b1;
    pulse_user();
    n = 0;
    while (nFTWR === 1'b1 && n < 100) begin tick(); n++; end
    check("rst_mid_in_strobe", nFTWR, 1'b0);
    RST = 1'b1;
    tick();
    check("rst_mid_nftwr", nFTWR, 1'b1);
    check("rst_mid_ftdoe", FTDOE, 1'b0);
    check("rst_mid_busy", BUSY, 1'b0);
    check("rst_mid_overrun", OVERRUN, 1'b0);
    RST = 1'b0;
    tick();
    clear_capture();
    pulse_user();
    check("user2_busy", BUSY, 1'b1);
    wait_busy_low("user2", 4000);
    exp_q.delete();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'hA5);
    repeat (256) exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    check_frame("user2");

    // nEN raised during payload byte 10 (frame byte 13): finish it, then stop.
    clear_capture();
    FIFORELPAGE = 12'h010; BITWIDTH4 = 1'b0;
    pulse_user();
    wait_bytes("nen", 14, 400);
    nEN = 1'b1;
    n = 0;
    while (BUSY === 1'b1 && n < 50) begin tick(); n++; end
    check("nen_busy_drop_cycles", n, 9);
    repeat (20) tick();
    check("nen_byte_count", bytes_q.size(), 14);
    check("nen_pulse_count", lowlen_q.size(), 14);
    if (lowlen_q.size() == 14) check("nen_last_lowlen", lowlen_q[13], WR_LOW);
    if (bytes_q.size() >= 14) check("nen_last_byte", bytes_q[13], 8'hFF);
    check("nen_ftdoe_off", FTDOE, 1'b0);

    // Requests are ignored while disabled.
    pulse_user();
    repeat (4) tick();
    check("disabled_ignore", BUSY, 1'b0);
    nEN = 1'b0;
    repeat (4) tick();
    check("enable_no_stale", BUSY, 1'b0);
    check("final_no_overrun", OVERRUN, 1'b0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
